// File: rtl/dmem_port_arbiter_if.sv
// Host register-access bus into the data-memory arbiter.
// The host is the master; the arbiter answers with grant and read data.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) ();
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU M stage and the host bus.
// The host wins when the CPU is idle or once it has waited HOST_MAX_WAIT cycles.
module dmem_port_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 64,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               LW_M,
    input  logic               SW_M,
    input  logic [DATA_W-1:0]  ALU_result_M,
    input  logic [DATA_W-1:0]  rt_data_M,
    output logic               mem_stall,
    output logic               load_valid,
    output logic [DATA_W-1:0]  load_data,
    dmem_port_arbiter_if.slave host,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_din,
    input  logic [DATA_W-1:0]  mem_dout,
    output logic [15:0]        stall_cnt
);

    localparam logic [1:0] TAG_NONE    = 2'd0;
    localparam logic [1:0] TAG_CPU_RD  = 2'd1;
    localparam logic [1:0] TAG_HOST_RD = 2'd2;

    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    logic [3:0]  r_wcnt;
    logic [1:0]  r_tag;
    logic [15:0] r_stall_cnt;

    logic       w_cpu_req;
    logic       w_host_win;
    logic       w_cpu_win;
    logic [1:0] w_tag_nxt;
    logic       w_unused_addr_hi;

    assign w_cpu_req        = LW_M | SW_M;
    assign w_unused_addr_hi = ^ALU_result_M[DATA_W-1:ADDR_W];

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_host_win = 1'b0;
        w_cpu_win  = 1'b0;
        if (!rst) begin
            w_host_win = host.host_req & (~w_cpu_req | (r_wcnt == MAX_WAIT));
            w_cpu_win  = w_cpu_req & ~w_host_win;
        end
    end

    always_comb begin
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_din       = '0;
        mem_stall     = 1'b0;
        host.host_gnt = 1'b0;
        w_tag_nxt     = TAG_NONE;
        if (w_host_win) begin
            mem_en        = 1'b1;
            mem_we        = host.host_we;
            mem_addr      = host.host_addr;
            mem_din       = host.host_wdata;
            host.host_gnt = 1'b1;
            // The held LW/SW is re-presented next cycle, when wcnt is back at 0.
            mem_stall     = w_cpu_req;
            w_tag_nxt     = host.host_we ? TAG_NONE : TAG_HOST_RD;
        end else if (w_cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = SW_M;
            mem_addr  = ALU_result_M[ADDR_W-1:0];
            mem_din   = rt_data_M;
            w_tag_nxt = SW_M ? TAG_NONE : TAG_CPU_RD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt      <= '0;
            r_tag       <= TAG_NONE;
            r_stall_cnt <= '0;
        end else begin
            r_tag <= w_tag_nxt;
            if (!host.host_req || w_host_win) begin
                r_wcnt <= '0;
            end else if (r_wcnt != MAX_WAIT) begin
                r_wcnt <= r_wcnt + 4'd1;
            end
            if (mem_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Read data is suppressed during reset even if a read was in flight.
    always_comb begin
        load_valid       = ~rst & (r_tag == TAG_CPU_RD);
        host.host_rvalid = ~rst & (r_tag == TAG_HOST_RD);
        load_data        = load_valid ? mem_dout : '0;
        host.host_rdata  = host.host_rvalid ? mem_dout : '0;
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single-port data memory between the pipeline's memory stage (LW/SW arriving from the EX/M stage register) and the host register-access interface used to load and inspect data memory. The block issues at most one memory access per cycle and routes synchronous read data back to its owner. When the CPU loses arbitration it drives a stall that freezes the pipeline. A wait counter guarantees the host cannot be starved.

## Interface
- ADDR_W, 8, data memory word-address width
- DATA_W, 64, data word width
- HOST_MAX_WAIT, 4, number of cycles a requesting host may lose before it takes priority; legal range 1..15
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- LW_M  in  1  load in M stage
- SW_M  in  1  store in M stage
- ALU_result_M  in  DATA_W  effective address; bits [ADDR_W-1:0] are used
- rt_data_M  in  DATA_W  store data
- mem_stall  out  1  pipeline freeze: PC, IF/ID, ID/EX and EX/M hold
- load_valid  out  1  CPU read data valid this cycle
- load_data  out  DATA_W  CPU read data; 0 when load_valid=0
- host_req  in  1  host access request, level; held until granted
- host_we  in  1  host write (1) or read (0)
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access issued this cycle
- host_rvalid  out  1  host read data valid this cycle
- host_rdata  out  DATA_W  host read data; 0 when host_rvalid=0
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data, valid the cycle after a read with mem_en=1 and mem_we=0
- stall_cnt  out  16  saturating count of cycles with mem_stall=1

## Operation
- CPU request: cpu_req = LW_M | SW_M. If both LW_M and SW_M are set, the access is a store and LW_M is ignored.
- Wait counter wcnt, 4 bits:
  - Cleared when host_req=0 or when host_gnt=1.
  - Otherwise increments when host_req=1 and the host loses arbitration, saturating at HOST_MAX_WAIT.
- Grant decision, combinational and evaluated each cycle:
  - host wins if host_req & (~cpu_req | wcnt==HOST_MAX_WAIT);
  - otherwise the CPU wins if cpu_req;
  - otherwise no access is issued.
- CPU wins:
  - mem_en=1; mem_we=SW_M; mem_addr=ALU_result_M[ADDR_W-1:0]; mem_din=rt_data_M; mem_stall=0.
- Host wins:
  - mem_en=1; mem_we=host_we; mem_addr=host_addr; mem_din=host_wdata; host_gnt=1.
  - mem_stall=cpu_req, so the pipeline holds and the same LW/SW is re-presented next cycle.
- No access: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- Read tag register, states NONE / CPU_RD / HOST_RD:
  - Next state is CPU_RD for an issued CPU load, HOST_RD for an issued host read, NONE otherwise.
  - Tag CPU_RD: load_valid=1, load_data=mem_dout.
  - Tag HOST_RD: host_rvalid=1, host_rdata=mem_dout.
- stall_cnt increments on every cycle with mem_stall=1 and saturates at 16'hFFFF.
- Reset:
  - wcnt=0, tag=NONE, stall_cnt=0.
  - While rst=1, all combinational outputs are forced to 0: mem_en, mem_we, mem_addr, mem_din, host_gnt, mem_stall.
  - load_valid, host_rvalid, load_data and host_rdata are 0 while rst=1 and in the cycle after.
  - A read in flight when rst asserts is discarded.

## Timing
- CPU store: written on the edge ending its M cycle; zero added latency.
- CPU load: issued in cycle N; load_valid=1 and load_data=mem_dout in cycle N+1, aligned with WB.
- Host access: host_gnt is asserted in the issue cycle N; for a read, host_rvalid is asserted in N+1.
  - The host must hold req/we/addr/wdata stable until host_gnt=1.
  - The host deasserts or changes its request in the cycle after host_gnt.
- Host starvation bound: a continuously requesting host is granted within HOST_MAX_WAIT+1 cycles of raising host_req.
- CPU stall bound: at most 1 consecutive stall cycle per host grant.
  - After a host grant, wcnt=0, so the CPU wins the next cycle whenever it is requesting.
- Back-to-back: consecutive CPU loads issue every cycle, and each returns its data one cycle later.
- Mixed back-to-back: a host read followed next cycle by a CPU load returns host_rvalid, then load_valid, on consecutive cycles.

## Test plan
- Reset: hold rst 2 cycles with host_req=1 and LW_M=1. Required: all outputs 0, stall_cnt=0, and no mem_en.
- CPU only:
  - SW_M=1, addr 5, data 64'h9 in cycle 1.
  - LW_M=1, addr 5 in cycle 2.
  - Required: mem_we=1 in cycle 1; load_valid=1 and load_data=9 in cycle 3; mem_stall never asserts.
- Host only:
  - Host write addr 3, data 64'hABCD, then host read addr 3.
  - Required: host_gnt pulses in each issue cycle; host_rvalid=1 and host_rdata=64'hABCD one cycle after the read grant.
- Starvation with HOST_MAX_WAIT=4:
  - LW_M held at 1 continuously; host_req raised in cycle 0.
  - Required: CPU is granted in cycles 0-3.
  - Cycle 4: host_gnt=1 and mem_stall=1.
  - Cycle 5: CPU is granted; stall_cnt=1.
- Both LW_M and SW_M set, addr 7, data 64'h1. Required: a write is performed and load_valid stays 0 the next cycle.
- Reset mid-read: host read granted in cycle N, rst=1 in cycle N+1. Required: host_rvalid=0 in N+1 and N+2, and wcnt=0.
